spi_slave_rx: RTL and testbench

SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

---
 rtl/spi_slave_rx.sv | 195 +++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receive-only slave with address filtering and a 16-byte RX FIFO.
// All SPI pins are resampled into the Mclk domain; the frame FSM decodes the
// leading address byte and forwards the following data bytes into the FIFO.
module spi_slave_rx #(
    parameter logic [7:0] MY_ADDR    = 8'hA5,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic                          Mclk,
    input  logic                          nReset,
    input  logic                          SPI_clk,
    input  logic                          SPI_CS,
    input  logic                          SPI_MOSI,
    input  logic                          Read_RQ,
    input  logic                          Clear_Flags,
    output logic [7:0]                    Data_Out,
    output logic                          Data_Available,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   usedw,
    output logic                          overrun,
    output logic                          frame_err
);

    localparam int             AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        SKIP = 2'd3
    } state_t;

    // Synchronizer stages: _p0/_p1 form the 2-flop synchronizer, _p2 is the
    // delayed copy used only for edge detection.
    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1;

    // After reset the synchronizer still holds its forced idle values for two
    // cycles; a CS pin that is already low would look like a fresh falling
    // edge. The arm flag only lets a frame start once CS has been seen high.
    logic [1:0] warm;
    logic       armed;

    logic sclk_rise, cs_rise, cs_fall;

    state_t     state, state_nxt;
    logic [2:0] bitcnt, bitcnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic       push_nxt;
    logic       ferr_set;

    // Byte-complete strobe; shreg holds the completed byte while it is high.
    logic       push_vld_p1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          pop, push_ok, ovr_set;

    // Resample the asynchronous SPI pins into the Mclk domain.
    always_ff @(posedge Mclk or posedge nReset) begin
        if (nReset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            cs_p0   <= 1'b1;
            cs_p1   <= 1'b1;
            cs_p2   <= 1'b1;
            mosi_p0 <= 1'b0;
            mosi_p1 <= 1'b0;
        end else begin
            sclk_p0 <= SPI_clk;
            sclk_p1 <= sclk_p0;
            sclk_p2 <= sclk_p1;
            cs_p0   <= SPI_CS;
            cs_p1   <= cs_p0;
            cs_p2   <= cs_p1;
            mosi_p0 <= SPI_MOSI;
            mosi_p1 <= mosi_p0;
        end
    end

    // Track synchronizer refill after reset and arm frame detection on CS high.
    always_ff @(posedge Mclk or posedge nReset) begin
        if (nReset) begin
            warm  <= 2'd0;
            armed <= 1'b0;
        end else begin
            if (warm != 2'd2)
                warm <= warm + 2'd1;
            if (warm == 2'd2 && cs_p1)
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_p1 & ~sclk_p2;
    assign cs_rise   = cs_p1 & ~cs_p2;
    assign cs_fall   = ~cs_p1 & cs_p2 & armed;

    // Frame FSM state, bit counter and shift register.
    always_ff @(posedge Mclk or posedge nReset) begin
        if (nReset) begin
            state       <= IDLE;
            bitcnt      <= 3'd0;
            shreg       <= 8'h00;
            push_vld_p1 <= 1'b0;
        end else begin
            state       <= state_nxt;
            bitcnt      <= bitcnt_nxt;
            shreg       <= shreg_nxt;
            push_vld_p1 <= push_nxt;
        end
    end

    // Next-state decode: frame start/stop, bit shifting and byte completion.
    always_comb begin
        state_nxt  = state;
        bitcnt_nxt = bitcnt;
        shreg_nxt  = shreg;
        push_nxt   = 1'b0;
        ferr_set   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt  = ADDR;
                    bitcnt_nxt = 3'd0;
                    shreg_nxt  = 8'h00;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_nxt  = IDLE;
                    ferr_set   = (bitcnt != 3'd0);
                    bitcnt_nxt = 3'd0;
                end else if (sclk_rise && !cs_p1) begin
                    shreg_nxt  = {shreg[6:0], mosi_p1};
                    bitcnt_nxt = bitcnt + 3'd1;
                    if (bitcnt == 3'd7) begin
                        case (state)
                            ADDR:    state_nxt = (shreg_nxt == MY_ADDR) ? DATA : SKIP;
                            DATA:    push_nxt  = 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    assign pop     = Read_RQ & (usedw != '0);
    // A full FIFO still accepts the byte when a pop frees a slot this cycle.
    assign push_ok = push_vld_p1 & ((usedw != DEPTH_CNT) | Read_RQ);
    assign ovr_set = push_vld_p1 & ~push_ok;

    // FIFO storage; contents are qualified by usedw so they need no reset.
    always_ff @(posedge Mclk) begin
        if (push_ok)
            mem[wr_ptr] <= shreg;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Mclk or posedge nReset) begin
        if (nReset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   usedw <= usedw + (AW+1)'(1);
                2'b01:   usedw <= usedw - (AW+1)'(1);
                default: usedw <= usedw;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge Mclk or posedge nReset) begin
        if (nReset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set  | (overrun   & ~Clear_Flags);
            frame_err <= ferr_set | (frame_err & ~Clear_Flags);
        end
    end

    assign Data_Available = (usedw != '0);
    assign full           = (usedw == DEPTH_CNT);
    assign Data_Out       = Data_Available ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames plus randomized frames, checked
// against a frame-level queue model of the receive FIFO and error flags.
module tb_spi_slave_rx;

    localparam logic [7:0] ADDR = 8'hA5;
    localparam int         HALF = 6;

    logic       Mclk = 1'b0;
    logic       nReset;
    logic       SPI_clk, SPI_CS, SPI_MOSI;
    logic       Read_RQ, Clear_Flags;
    logic [7:0] Data_Out;
    logic       Data_Available, full;
    logic [4:0] usedw;
    logic       overrun, frame_err;

    spi_slave_rx #(.MY_ADDR(ADDR), .FIFO_DEPTH(16)) dut (
        .Mclk(Mclk), .nReset(nReset), .SPI_clk(SPI_clk), .SPI_CS(SPI_CS),
        .SPI_MOSI(SPI_MOSI), .Read_RQ(Read_RQ), .Clear_Flags(Clear_Flags),
        .Data_Out(Data_Out), .Data_Available(Data_Available), .full(full),
        .usedw(usedw), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 Mclk = ~Mclk;

    int nchk  = 0;
    int npass = 0;
    int nfail = 0;

    // Reference model: bytes the slave must hold, and sticky flags.
    logic [7:0] exp_q[$];
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;

    logic [7:0] tx_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nchk++;
        assert (obs === expv) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_status(input string tag);
        @(negedge Mclk);
        chk({tag, ".usedw"},     32'(usedw),     32'(exp_q.size()));
        chk({tag, ".avail"},     32'(Data_Available), 32'(exp_q.size() != 0));
        chk({tag, ".full"},      32'(full),      32'(exp_q.size() == 16));
        chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
        chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
    endtask

    // One SPI mode-0 bit; optionally pulse Read_RQ in the cycle the completed
    // byte is pushed into the FIFO (4th Mclk edge after the SPI_clk rise).
    task automatic spi_bit(input logic b, input bit rd_at_push);
        SPI_MOSI = b;
        repeat (HALF) @(negedge Mclk);
        SPI_clk = 1'b1;
        if (rd_at_push) begin
            repeat (3) @(negedge Mclk);
            chk("pop_at_push.data", 32'(Data_Out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            Read_RQ = 1'b1;
            @(negedge Mclk);
            Read_RQ = 1'b0;
            repeat (HALF - 4) @(negedge Mclk);
        end else begin
            repeat (HALF) @(negedge Mclk);
        end
        SPI_clk = 1'b0;
    endtask

    // Send tx_q as one frame, then npart extra bits before CS rises.
    task automatic send_frame(input int npart, input int rd_idx);
        logic [7:0] cur;
        @(negedge Mclk);
        SPI_CS = 1'b0;
        repeat (HALF) @(negedge Mclk);
        for (int i = 0; i < tx_q.size(); i++) begin
            cur = tx_q[i];
            for (int b = 7; b >= 0; b--)
                spi_bit(cur[b], (i == rd_idx) && (b == 0));
        end
        for (int k = 0; k < npart; k++)
            spi_bit(1'($urandom_range(0, 1)), 1'b0);
        repeat (HALF) @(negedge Mclk);
        SPI_CS = 1'b1;
        repeat (2 * HALF) @(negedge Mclk);
    endtask

    // Frame-level rule: data bytes after a matching address are stored while
    // space remains, otherwise dropped with overrun; a partial byte is an error.
    task automatic model_frame(input int npart);
        if (tx_q.size() > 0 && tx_q[0] == ADDR) begin
            for (int i = 1; i < tx_q.size(); i++) begin
                if (exp_q.size() < 16) exp_q.push_back(tx_q[i]);
                else m_ovr = 1'b1;
            end
        end
        if (npart > 0) m_ferr = 1'b1;
    endtask

    task automatic do_read(input string tag);
        @(negedge Mclk);
        if (exp_q.size() != 0) begin
            chk(tag, 32'(Data_Out), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end else begin
            chk(tag, 32'(Data_Out), 32'h0);
        end
        Read_RQ = 1'b1;
        @(negedge Mclk);
        Read_RQ = 1'b0;
    endtask

    task automatic clear_flags();
        @(negedge Mclk);
        Clear_Flags = 1'b1;
        @(negedge Mclk);
        Clear_Flags = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    initial begin
        logic [7:0] a;
        int         n, np, nr;

        nReset = 1'b1;
        SPI_clk = 1'b0; SPI_CS = 1'b1; SPI_MOSI = 1'b0;
        Read_RQ = 1'b0; Clear_Flags = 1'b0;
        repeat (3) @(negedge Mclk);
        chk("reset.usedw", 32'(usedw), 32'h0);
        chk("reset.avail", 32'(Data_Available), 32'h0);
        chk("reset.full", 32'(full), 32'h0);
        chk("reset.dout", 32'(Data_Out), 32'h0);
        chk("reset.overrun", 32'(overrun), 32'h0);
        chk("reset.frame_err", 32'(frame_err), 32'h0);
        nReset = 1'b0;
        repeat (4) @(negedge Mclk);

        // Basic frame, read back in order
        tx_q = '{ADDR, 8'h11, 8'h22, 8'h33};
        send_frame(0, -1); model_frame(0);
        check_status("basic");
        for (int i = 0; i < 3; i++) do_read("basic.rd");
        check_status("basic.drained");

        // Read on an empty FIFO is ignored
        do_read("empty.rd");
        check_status("empty");

        // Address mismatch
        tx_q = '{8'h3C, 8'h55};
        send_frame(0, -1); model_frame(0);
        check_status("mismatch");

        // Overflow: 18 data bytes, 16 kept
        tx_q = '{ADDR};
        for (int i = 0; i < 18; i++) tx_q.push_back(8'(8'h40 + i));
        send_frame(0, -1); model_frame(0);
        check_status("overflow");
        clear_flags();
        check_status("overflow.clear");

        // Full FIFO, pop in the push cycle keeps the byte and avoids overrun
        tx_q = '{ADDR, 8'hC7};
        send_frame(0, 1); model_frame(0);
        check_status("push_pop_full");
        for (int i = 0; i < 16; i++) do_read("push_pop_full.rd");
        check_status("push_pop_full.drained");

        // Partial byte then a good frame
        tx_q = '{ADDR};
        send_frame(5, -1); model_frame(5);
        check_status("partial");
        tx_q = '{ADDR, 8'h77};
        send_frame(0, -1); model_frame(0);
        check_status("after_partial");
        do_read("after_partial.rd");
        clear_flags();
        check_status("after_partial.clear");

        // Mid-byte reset with data stored and an error flag pending
        tx_q = '{ADDR, 8'h44};
        send_frame(3, -1); model_frame(3);
        check_status("pre_reset");
        @(negedge Mclk);
        SPI_CS = 1'b0;
        repeat (HALF) @(negedge Mclk);
        for (int k = 0; k < 3; k++) spi_bit(1'b1, 1'b0);
        nReset = 1'b1;
        #1;
        chk("midreset.usedw", 32'(usedw), 32'h0);
        chk("midreset.avail", 32'(Data_Available), 32'h0);
        chk("midreset.full", 32'(full), 32'h0);
        chk("midreset.dout", 32'(Data_Out), 32'h0);
        chk("midreset.overrun", 32'(overrun), 32'h0);
        chk("midreset.frame_err", 32'(frame_err), 32'h0);
        repeat (2) @(negedge Mclk);
        nReset = 1'b0;
        exp_q.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        for (int k = 0; k < 3; k++) spi_bit(1'b0, 1'b0);
        repeat (HALF) @(negedge Mclk);
        SPI_CS = 1'b1;
        repeat (2 * HALF) @(negedge Mclk);
        check_status("post_reset");
        tx_q = '{ADDR, 8'h99};
        send_frame(0, -1); model_frame(0);
        check_status("post_reset.frame");
        do_read("post_reset.rd");

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) != 0) a = ADDR;
            else begin
                a = 8'($urandom);
                if (a == ADDR) a = 8'h5A;
            end
            tx_q = '{a};
            n = $urandom_range(0, 6);
            for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
            np = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            send_frame(np, -1); model_frame(np);
            check_status("rand");
            nr = $urandom_range(0, exp_q.size());
            for (int i = 0; i < nr; i++) do_read("rand.rd");
            if ($urandom_range(0, 1) == 1) begin
                clear_flags();
                check_status("rand.clear");
            end
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
